// File: rtl/usb_csr_pkg.sv
// Shared constants for the USB control/status register block: register
// offsets, EVENT bit positions and AXI response codes.
package usb_csr_pkg;

    // Byte offsets of the registers; the block decodes address bits [ADDR_W-1:2]
    localparam logic [31:0] CSR_CTRL    = 32'h00;
    localparam logic [31:0] CSR_STATUS  = 32'h04;
    localparam logic [31:0] CSR_EVENT   = 32'h08;
    localparam logic [31:0] CSR_IRQ_EN  = 32'h0C;
    localparam logic [31:0] CSR_SCRATCH = 32'h10;
    localparam logic [31:0] CSR_ID      = 32'h14;

    // Sticky EVENT bit positions
    localparam int EV_BUS_RESET = 0;
    localparam int EV_VBUS_CHG  = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/usb_csr_axil_slave.sv
// AXI4-Lite register responder for USB device control. Owns the connect
// request, read-only ULPI status, sticky W1C event bits and a level irq.
// Everything runs on ulpi_clk.
module usb_csr_axil_slave
    import usb_csr_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] ID_VALUE = 32'h5553_4231
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              usb_connected,
    input  logic [1:0]        line_state,
    input  logic              vbus_valid,
    input  logic              bus_reset,
    output logic              irq
);

    localparam logic [ADDR_W-3:0] IDX_CTRL    = CSR_CTRL[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_STATUS  = CSR_STATUS[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_EVENT   = CSR_EVENT[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_IRQ_EN  = CSR_IRQ_EN[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_SCRATCH = CSR_SCRATCH[ADDR_W-1:2];
    localparam logic [ADDR_W-3:0] IDX_ID      = CSR_ID[ADDR_W-1:2];

    // Per-byte merge of write data into an existing register value
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Write channel state
    logic              aw_held, w_held;
    logic [ADDR_W-3:0] aw_idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    // Register file
    logic        ctrl_conn;
    logic [1:0]  event_q;
    logic [1:0]  irq_en_q;
    logic [31:0] scratch_q;
    logic        vbus_q;

    // Combinational channel helpers
    logic              aw_hs, w_hs, ar_hs;
    logic              aw_held_n, w_held_n, wr_commit;
    logic              bvalid_n, rvalid_n;
    logic [ADDR_W-3:0] wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_known;
    logic [31:0]       rd_val;
    logic [1:0]        rd_resp;
    logic [1:0]        ev_set, ev_clr;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs     = s_axi_awvalid & s_axi_awready;
    assign w_hs      = s_axi_wvalid & s_axi_wready;
    assign ar_hs     = s_axi_arvalid & s_axi_arready;
    assign aw_held_n = aw_held | aw_hs;
    assign w_held_n  = w_held | w_hs;
    assign wr_commit = aw_held_n & w_held_n & ~s_axi_bvalid;
    assign bvalid_n  = wr_commit | (s_axi_bvalid & ~s_axi_bready);
    assign rvalid_n  = ar_hs | (s_axi_rvalid & ~s_axi_rready);

    assign wr_idx  = aw_hs ? s_axi_awaddr[ADDR_W-1:2] : aw_idx_q;
    assign wr_data = w_hs ? s_axi_wdata : wdata_q;
    assign wr_strb = w_hs ? s_axi_wstrb : wstrb_q;

    assign wr_known = (wr_idx == IDX_CTRL)    || (wr_idx == IDX_STATUS) ||
                      (wr_idx == IDX_EVENT)   || (wr_idx == IDX_IRQ_EN) ||
                      (wr_idx == IDX_SCRATCH) || (wr_idx == IDX_ID);

    assign ev_set[EV_BUS_RESET] = bus_reset;
    assign ev_set[EV_VBUS_CHG]  = vbus_valid ^ vbus_q;
    assign ev_clr = (wr_commit && wr_idx == IDX_EVENT && wr_strb[0]) ? wr_data[1:0] : 2'b00;

    assign usb_connected = ctrl_conn;

    // Read data mux on the incoming AR address; unmapped offsets give SLVERR
    always_comb begin
        rd_val  = 32'h0;
        rd_resp = RESP_OKAY;
        case (s_axi_araddr[ADDR_W-1:2])
            IDX_CTRL:    rd_val = {31'h0, ctrl_conn};
            IDX_STATUS:  rd_val = {29'h0, vbus_valid, line_state};
            IDX_EVENT:   rd_val = {30'h0, event_q};
            IDX_IRQ_EN:  rd_val = {30'h0, irq_en_q};
            IDX_SCRATCH: rd_val = scratch_q;
            IDX_ID:      rd_val = ID_VALUE;
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    // Write channel: hold AW and W independently, commit once both are present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= 32'h0;
            wstrb_q       <= 4'h0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_W-1:2];
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            aw_held       <= aw_held_n & ~wr_commit;
            w_held        <= w_held_n & ~wr_commit;
            s_axi_awready <= ~(aw_held_n & ~wr_commit) & ~bvalid_n;
            s_axi_wready  <= ~(w_held_n & ~wr_commit) & ~bvalid_n;
            s_axi_bvalid  <= bvalid_n;
            if (wr_commit) s_axi_bresp <= wr_known ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read channel: capture data at the AR handshake, hold until rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'h0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            s_axi_arready <= ~rvalid_n;
            s_axi_rvalid  <= rvalid_n;
            if (ar_hs) begin
                s_axi_rdata <= rd_val;
                s_axi_rresp <= rd_resp;
            end
        end
    end

    // Register file, sticky events (set beats clear) and registered irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_conn <= 1'b0;
            event_q   <= 2'b00;
            irq_en_q  <= 2'b00;
            scratch_q <= 32'h0;
            vbus_q    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            vbus_q  <= vbus_valid;
            event_q <= (event_q & ~ev_clr) | ev_set;
            irq     <= |(event_q & irq_en_q);
            if (wr_commit && wr_strb[0] && wr_idx == IDX_CTRL)   ctrl_conn <= wr_data[0];
            if (wr_commit && wr_strb[0] && wr_idx == IDX_IRQ_EN) irq_en_q  <= wr_data[1:0];
            if (wr_commit && wr_idx == IDX_SCRATCH)
                scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
        end
    end

endmodule

// File: tb/tb_usb_csr_axil_slave.sv
// Bench for usb_csr_axil_slave: directed vector table, hand-timed corner
// sequences and a randomized phase checked against a register-map model.
module tb_usb_csr_axil_slave;

    localparam logic [31:0] ID = 32'h5553_4231;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        usb_connected, vbus_valid, bus_reset, irq;
    logic [1:0]  line_state;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_ctrl;
    logic [1:0]  m_en, m_ev;
    logic [31:0] m_scratch;

    always #5 clk = ~clk;

    usb_csr_axil_slave #(.ADDR_W(8), .ID_VALUE(ID)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .usb_connected(usb_connected), .line_state(line_state), .vbus_valid(vbus_valid),
        .bus_reset(bus_reset), .irq(irq)
    );

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting for DUT handshake", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done;
        int n;
        resp = 2'b11;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready) w_done = 1'b1;
            tick();
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            timed_out("wr_addr_data");
            return;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bvalid) begin
            timed_out("wr_resp");
            return;
        end
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        d = 32'hx; resp = 2'b11;
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        if (!arready) begin
            arvalid = 1'b0;
            timed_out("rd_addr");
            return;
        end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        if (!rvalid) begin
            timed_out("rd_data");
            return;
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // Model: what a read of a byte address should return
    function automatic logic [33:0] model_read(input logic [7:0] a);
        case (a[7:2])
            6'd0:    return {2'b00, 31'h0, m_ctrl};
            6'd1:    return {2'b00, 29'h0, vbus_valid, line_state};
            6'd2:    return {2'b00, 30'h0, m_ev};
            6'd3:    return {2'b00, 30'h0, m_en};
            6'd4:    return {2'b00, m_scratch};
            6'd5:    return {2'b00, ID};
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        case (a[7:2])
            6'd0: if (s[0]) m_ctrl = d[0];
            6'd2: if (s[0]) m_ev = m_ev & ~d[1:0];
            6'd3: if (s[0]) m_en = d[1:0];
            6'd4: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [33:0] exp;
        logic [7:0]  addrs[10];
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40, 8'h13, 8'hFC};

        vecs[0]  = '{0, 8'h14, 32'h0,        4'h0,    ID,           2'b00};
        vecs[1]  = '{0, 8'h00, 32'h0,        4'h0,    32'h1,        2'b00};
        vecs[2]  = '{1, 8'h10, 32'hA5A5A5A5, 4'b0101, 32'h0,        2'b00};
        vecs[3]  = '{0, 8'h10, 32'h0,        4'h0,    32'h00A500A5, 2'b00};
        vecs[4]  = '{1, 8'h0C, 32'hFFFFFFFF, 4'hF,    32'h0,        2'b00};
        vecs[5]  = '{0, 8'h0C, 32'h0,        4'h0,    32'h3,        2'b00};
        vecs[6]  = '{1, 8'h40, 32'hFFFFFFFF, 4'hF,    32'h0,        2'b10};
        vecs[7]  = '{0, 8'h40, 32'h0,        4'h0,    32'h0,        2'b10};
        vecs[8]  = '{0, 8'h10, 32'h0,        4'h0,    32'h00A500A5, 2'b00};
        vecs[9]  = '{1, 8'h14, 32'h0,        4'hF,    32'h0,        2'b00};
        vecs[10] = '{0, 8'h14, 32'h0,        4'h0,    ID,           2'b00};
        vecs[11] = '{0, 8'h04, 32'h0,        4'h0,    32'h1,        2'b00};
        vecs[12] = '{1, 8'h00, 32'h0,        4'h0,    32'h0,        2'b00};
        vecs[13] = '{0, 8'h00, 32'h0,        4'h0,    32'h1,        2'b00};
        vecs[14] = '{1, 8'h10, 32'hFFFFFFFF, 4'b1010, 32'h0,        2'b00};
        vecs[15] = '{0, 8'h10, 32'h0,        4'h0,    32'hFFA5FFA5, 2'b00};

        rst = 1'b1;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        vbus_valid = 0; bus_reset = 0; line_state = 2'b01;

        // Reset state
        repeat (3) tick();
        check("reset_ready", {29'h0, awready, wready, arready}, 32'h0);
        check("reset_valid", {30'h0, bvalid, rvalid}, 32'h0);
        check("reset_resp", {28'h0, bresp, rresp}, 32'h0);
        check("reset_outs", {30'h0, usb_connected, irq}, 32'h0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", {29'h0, awready, wready, arready}, 32'h7);

        // Read ID: rvalid one cycle after AR
        araddr = 8'h14; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("id_rvalid", {31'h0, rvalid}, 32'h1);
        check("id_rdata", rdata, ID);
        check("id_rresp", {30'h0, rresp}, 32'h0);
        rready = 1'b1; tick(); rready = 1'b0;
        check("id_rvalid_drop", {31'h0, rvalid}, 32'h0);

        // AW first, W four cycles later
        awaddr = 8'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        repeat (3) tick();
        check("aw_only_no_commit", {30'h0, bvalid, usb_connected}, 32'h0);
        check("aw_only_wready", {30'h0, awready, wready}, 32'h1);
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("split_bvalid", {31'h0, bvalid}, 32'h1);
        check("split_connected", {31'h0, usb_connected}, 32'h1);
        check("split_bresp", {30'h0, bresp}, 32'h0);
        bready = 1'b1; tick(); bready = 1'b0;
        check("split_bvalid_drop", {31'h0, bvalid}, 32'h0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), {30'h0, rs}, {30'h0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'h0, rs}, {30'h0, vecs[i].exp_resp});
            end
        end

        // Backpressure on B: no new write accepted while the response waits
        awaddr = 8'h10; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bstall%0d", i), {29'h0, awready, wready, bvalid}, 32'h1);
            tick();
        end
        bready = 1'b1; tick(); bready = 1'b0;
        axi_read(8'h10, rd, rs);
        check("bstall_readback", rd, 32'h12345678);

        // Interrupt from bus reset and W1C clear
        axi_write(8'h0C, 32'h1, 4'hF, rs);
        bus_reset = 1'b1; tick(); bus_reset = 1'b0;
        check("irq_lag", {31'h0, irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, irq}, 32'h1);
        axi_read(8'h08, rd, rs);
        check("event_set", rd, 32'h1);
        axi_write(8'h08, 32'h1, 4'hF, rs);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        axi_read(8'h08, rd, rs);
        check("event_cleared", rd, 32'h0);

        // Set and clear in the same cycle: set wins
        awaddr = 8'h08; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bus_reset = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; bus_reset = 1'b0;
        check("coinc_bvalid", {31'h0, bvalid}, 32'h1);
        bready = 1'b1; tick(); bready = 1'b0;
        axi_read(8'h08, rd, rs);
        check("coinc_event_kept", rd, 32'h1);
        check("coinc_irq", {31'h0, irq}, 32'h1);

        // Read of EVENT in the same cycle as its W1C sees the pre-clear value
        araddr = 8'h08; arvalid = 1'b1;
        awaddr = 8'h08; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("rw_same_cycle_valid", {30'h0, rvalid, bvalid}, 32'h3);
        check("rw_same_cycle_rdata", rdata, 32'h1);
        rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
        axi_read(8'h08, rd, rs);
        check("rw_same_cycle_after", rd, 32'h0);

        // VBUS change sets bit1; only raises irq when enabled
        vbus_valid = 1'b1;
        repeat (2) tick();
        axi_read(8'h08, rd, rs);
        check("vbus_event", rd, 32'h2);
        check("vbus_irq_masked", {31'h0, irq}, 32'h0);
        axi_write(8'h0C, 32'h2, 4'hF, rs);
        tick();
        check("vbus_irq_enabled", {31'h0, irq}, 32'h1);
        axi_read(8'h04, rd, rs);
        check("status_vbus", rd, 32'h5);
        axi_write(8'h08, 32'h2, 4'hF, rs);
        axi_read(8'h08, rd, rs);
        check("vbus_event_cleared", rd, 32'h0);

        // Reset in the middle of a read response
        araddr = 8'h14; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("midrst_rvalid_before", {31'h0, rvalid}, 32'h1);
        rst = 1'b1; vbus_valid = 1'b0;
        #1;
        check("midrst_rvalid_async", {31'h0, rvalid}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_no_replay", {31'h0, rvalid}, 32'h0);
        axi_read(8'h14, rd, rs);
        check("midrst_next_read", rd, ID);
        axi_read(8'h10, rd, rs);
        check("midrst_scratch_zero", rd, 32'h0);
        check("midrst_conn_zero", {31'h0, usb_connected}, 32'h0);

        // Randomized traffic against the register-map model
        m_ctrl = 1'b0; m_en = 2'b00; m_ev = 2'b00; m_scratch = 32'h0;
        for (int i = 0; i < 300; i++) begin
            line_state = 2'($urandom_range(0, 3));
            a = addrs[$urandom_range(0, 9)];
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0, 1: begin
                    axi_write(a, d, s, rs);
                    exp = model_read(a);
                    check($sformatf("rnd%0d_bresp", i), {30'h0, rs}, {30'h0, exp[33:32]});
                    model_write(a, d, s);
                end
                2: begin
                    axi_read(a, rd, rs);
                    exp = model_read(a);
                    check($sformatf("rnd%0d_rdata", i), rd, exp[31:0]);
                    check($sformatf("rnd%0d_rresp", i), {30'h0, rs}, {30'h0, exp[33:32]});
                end
                default: begin
                    bus_reset = 1'b1; tick(); bus_reset = 1'b0;
                    m_ev[0] = 1'b1;
                end
            endcase
            tick();
            check($sformatf("rnd%0d_irq", i), {31'h0, irq}, {31'h0, |(m_ev & m_en)});
            check($sformatf("rnd%0d_conn", i), {31'h0, usb_connected}, {31'h0, m_ctrl});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_csr_axil_slave.md
Name: usb_csr_axil_slave

Overview:
- AXI4-Lite register responder sitting on the MicroBlaze register master port (m_axi_reg_*).
- Replaces the debug VIO as the software path to USB device control.
- Drives the usb_control connect request, exposes ULPI/USB state as read-only status, latches USB events into sticky W1C bits, and raises a level interrupt.
- Runs entirely in the ulpi_clk domain; any clock crossing sits on the AXI side, outside this block.

Parameters:
- ADDR_W, 8, number of byte-address bits decoded; higher address bits are ignored.
- ID_VALUE, 32'h5553_4231, constant returned by the ID register.

Ports:
- clk  in  1  ulpi_clk.
- rst  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- usb_connected  out  1  connect request to the state controller.
- line_state  in  2  ULPI line state.
- vbus_valid  in  1  VBUS valid level.
- bus_reset  in  1  one-cycle bus-reset pulse.
- irq  out  1  level interrupt.
- AW/AR prot inputs are not connected.

Behaviour:
- Register map (offset, decoded from addr[ADDR_W-1:2]):
  - 0x00 CTRL, RW: bit0 = usb_connected; other bits read 0.
  - 0x04 STATUS, RO: bits[1:0] = line_state, bit2 = vbus_valid.
  - 0x08 EVENT, W1C: bit0 = bus reset seen, bit1 = vbus_valid changed.
  - 0x0C IRQ_EN, RW: bits[1:0].
  - 0x10 SCRATCH, RW: 32 bits.
  - 0x14 ID, RO: returns ID_VALUE.
  - Any other offset: reads return 0 with SLVERR (2'b10); writes change nothing and return SLVERR.
  - Writes to RO registers return OKAY and are ignored.
- Byte strobes apply per byte on all RW registers. A W1C clear only acts when wstrb[0]=1.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid. Both are registered and 0 during reset.
  - Address and data are latched independently and may arrive in either order or in the same cycle.
  - The write commits in the cycle both are held. bvalid rises the next cycle, together with the register update.
  - Latency: AW and W handshaken in cycle N gives bvalid=1 and the new value in cycle N+1.
  - bvalid and bresp hold until bready; at most one write is outstanding.
- Read channel:
  - arready = !rvalid, registered, 0 during reset.
  - rdata/rresp are captured at the AR handshake; rvalid=1 the next cycle and holds until rready. AR in cycle N gives rvalid in cycle N+1.
  - Values are stable while rvalid=1 and rready=0.
- Reads and writes are fully independent and may complete in the same cycle.
  - If a read of EVENT coincides with a W1C commit, the read returns the pre-clear value.
- EVENT bits:
  - bit0 sets on bus_reset=1.
  - bit1 sets on any change of registered vbus_valid; the reference copy is 0 after reset.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq is registered: irq = |(EVENT & IRQ_EN), updated one cycle after EVENT or IRQ_EN changes.
- Reset: all registers, usb_connected, irq, bvalid, rvalid, rdata and the held flags go to 0; bresp and rresp go to OKAY.
- Reset asserted mid-transaction drops any pending response; no response is replayed after reset.

Decomposition:
- Shared package usb_csr_pkg holds:
  - register offset constants (CSR_CTRL, CSR_STATUS, CSR_EVENT, CSR_IRQ_EN, CSR_SCRATCH, CSR_ID);
  - EVENT bit indices;
  - AXI response constants RESP_OKAY and RESP_SLVERR.
- No sub-module. The register file and both channel FSMs stay in one file, roughly 200 lines.

Test Plan:
- Reset, then read 0x14 → rvalid one cycle after AR, rdata=32'h5553_4231, rresp=OKAY.
- AW(0x00) in cycle 5 and W(32'h1, strb 4'hF) in cycle 9 → bvalid in cycle 10, usb_connected=1 from cycle 10, bresp=OKAY.
- Write 0x10 with data 32'hA5A5A5A5, strb 4'b0101, over an initial 0 → readback 32'h00A500A5.
- IRQ_EN=1, pulse bus_reset → EVENT=1, irq=1 one cycle later; W1C 0x08 with data 1 → EVENT=0, irq=0. Repeat with the pulse landing in the same cycle as the clear → EVENT stays 1.
- Read 0x40 and write 0x40 → rresp=2'b10 with rdata=0, bresp=2'b10, no register changes.
- Hold bready=0 for 8 cycles after a write → awready and wready stay 0 and bvalid stays asserted. Assert rst mid-read with rvalid=1 → rvalid=0 immediately; the next read proceeds normally.
